// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared definitions for the UART receiver: receiver FSM state
//                encoding, oversampling ratio, in-bit sample tick positions
//                and the 3-sample majority vote.
//  Config      : UART_RX_PARITY_EN adds the PARITY state to the encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Oversampling ratio: ticks per bit period.
  localparam int OSR = 16;

  // Positions (within the 16-tick bit) of the three majority-vote samples,
  // and the last tick of a bit period.
  localparam logic [3:0] SAMPLE_T0 = 4'd7;
  localparam logic [3:0] SAMPLE_T1 = 4'd8;
  localparam logic [3:0] SAMPLE_T2 = 4'd9;
  localparam logic [3:0] LAST_TICK = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3
`ifdef UART_RX_PARITY_EN
    ,
    ST_PARITY = 3'd4
`endif
  } uart_state_e;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO, power-of-two depth. Head entry is driven
//                combinationally; a pop takes effect on the next clock edge.
//                A push while full is accepted only when a pop happens in the
//                same cycle (count then stays unchanged).
//  Ports       : clk, rst (sync, active-high), push, pop, din[WIDTH],
//                dout[WIDTH] (0 when empty), full, empty
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Masking the head with empty makes dout read 0 after reset without
  // having to clear the storage array.
  assign dout = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo
//  Description : 8N1 UART receiver with 16x oversampling, 3-sample majority
//                vote per bit, and a receive FIFO.
//  Config      : define UART_RX_PARITY_EN for an even-parity bit between the
//                data bits and the stop bit (bad parity -> frame_err, drop).
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                rx            - asynchronous serial input, idle high
//                dout[7:0]     - FIFO head byte (valid while rdy)
//                rdy           - FIFO not empty
//                rd_en         - pop head byte (ignored while rdy is 0)
//                frame_err     - 1-cycle pulse on bad stop (or parity) bit
//                overrun       - 1-cycle pulse when a good byte is dropped
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_SPEED  = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] dout,
  output logic       rdy,
  input  logic       rd_en,
  output logic       frame_err,
  output logic       overrun
);

  localparam int DIV_RAW = CLK_SPEED / (BAUD * OSR);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  // --------------------------------------------------------------------------
  // Input synchroniser plus one extra stage for falling-edge detection.
  // --------------------------------------------------------------------------
  logic rx_meta;
  logic rx_sync;
  logic rx_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // --------------------------------------------------------------------------
  // Free-running oversample tick generator.
  // --------------------------------------------------------------------------
  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Receiver FSM
  // --------------------------------------------------------------------------
  uart_state_e state;
  logic [3:0]  bit_tick;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        samp_a;
  logic        samp_b;
  logic        wait_high;
  logic        maj;
  logic        parity_ok;
  logic        stop_sample;
  logic        good_byte;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_push;

  // The third vote is taken live at tick 9, so the decision for a bit is
  // available in the same cycle as its last sample.
  assign maj = majority3(samp_a, samp_b, rx_sync);

`ifdef UART_RX_PARITY_EN
  logic par_bad;
  assign parity_ok = !par_bad;
`else
  assign parity_ok = 1'b1;
`endif

  assign stop_sample = (state == ST_STOP) && !wait_high && tick && (bit_tick == SAMPLE_T2);
  assign good_byte   = stop_sample && maj && parity_ok;
  // A full FIFO still accepts the byte when the head is popped in this cycle.
  assign fifo_push   = good_byte && (!fifo_full || rd_en);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      bit_tick  <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      samp_a    <= 1'b0;
      samp_b    <= 1'b0;
      wait_high <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad   <= 1'b0;
`endif
    end else begin
      if (tick) begin
        bit_tick <= bit_tick + 4'd1;
        if (bit_tick == SAMPLE_T0) samp_a <= rx_sync;
        if (bit_tick == SAMPLE_T1) samp_b <= rx_sync;
      end

      case (state)
        ST_IDLE: begin
          if (rx_prev && !rx_sync) begin
            state    <= ST_START;
            bit_tick <= '0;
          end
        end

        ST_START: begin
          if (tick && (bit_tick == SAMPLE_T2) && maj) begin
            state <= ST_IDLE;               // false start: glitch on idle line
          end else if (tick && (bit_tick == LAST_TICK)) begin
            state   <= ST_DATA;
            bit_idx <= '0;
          end
        end

        ST_DATA: begin
          if (tick && (bit_tick == SAMPLE_T2)) begin
            shreg <= {maj, shreg[7:1]};     // LSB arrives first
          end
          if (tick && (bit_tick == LAST_TICK)) begin
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (tick && (bit_tick == SAMPLE_T2)) begin
            // Even parity: data ones plus parity bit must be even.
            par_bad <= maj ^ (^shreg);
          end
          if (tick && (bit_tick == LAST_TICK)) begin
            state <= ST_STOP;
          end
        end
`endif

        ST_STOP: begin
          if (wait_high) begin
            // After a bad stop bit, hold off until the line is idle again so
            // a break is not mistaken for a new start bit.
            if (rx_sync) begin
              state     <= ST_IDLE;
              wait_high <= 1'b0;
            end
          end else if (tick && (bit_tick == SAMPLE_T2)) begin
            if (maj) begin
              state <= ST_IDLE;
            end else begin
              wait_high <= 1'b1;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Status pulses
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_sample && (!maj || !parity_ok);
      overrun   <= good_byte && fifo_full && !rd_en;
    end
  end

  // --------------------------------------------------------------------------
  // Receive FIFO
  // --------------------------------------------------------------------------
  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (rd_en),
    .din   (shreg),
    .dout  (dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rdy = !fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_fifo
//  Description : Directed self-checking bench for uart_rx_fifo at 50 MHz /
//                115200 baud (27 clocks per tick, 432 clocks per bit).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int BIT_CLKS = 432;   // 16 * floor(50e6 / (115200*16)) = 16 * 27
`ifdef UART_RX_PARITY_EN
  localparam logic HAS_PARITY = 1'b1;
`else
  localparam logic HAS_PARITY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       rd_en;
  logic [7:0] dout;
  logic       rdy;
  logic       frame_err;
  logic       overrun;

  int   n_vec = 0;
  int   n_err = 0;
  int   frame_cyc;
  int   fe_hi;
  int   ov_hi;
  int   ov_total;
  int   rdy_rise;
  int   stop_start;
  logic rdy_prev;

  uart_rx_fifo #(
    .CLK_SPEED  (50000000),
    .BAUD       (115200),
    .FIFO_DEPTH (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .dout      (dout),
    .rdy       (rdy),
    .rd_en     (rd_en),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Hold rx at level b for ncyc clocks, observing outputs 1 time unit after
  // each rising edge. With pop_on_push, rd_en is raised in exactly the cycle
  // the receiver accepts a byte, to exercise simultaneous push/pop.
  task automatic drive_bit(input logic b, input int ncyc, input logic pop_on_push);
    rx = b;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      #1;
      frame_cyc++;
      if (frame_err) fe_hi++;
      if (overrun)   ov_hi++;
      if (rdy && !rdy_prev && rdy_rise < 0) rdy_rise = frame_cyc;
      rdy_prev = rdy;
      rd_en = pop_on_push && dut.good_byte;
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                            input logic par_bit, input logic pop_on_push);
    logic [10:0] bits;
    bits       = {stop_bit, par_bit, data, 1'b0};
    frame_cyc  = 0;
    fe_hi      = 0;
    ov_hi      = 0;
    rdy_rise   = -1;
    rdy_prev   = rdy;
    stop_start = 0;
    for (int i = 0; i < 11; i++) begin
      if (i == 9 && !HAS_PARITY) continue;
      if (i == 10) stop_start = frame_cyc;
      drive_bit(bits[i], BIT_CLKS, pop_on_push);
    end
    drive_bit(1'b1, 24, 1'b0);
    rd_en = 1'b0;
  endtask

  task automatic pop_byte();
    rd_en = 1'b1;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx = 1'b1; rd_en = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_vec++; if (rdy !== 1'b0) begin n_err++; $display("FAIL reset_rdy: got %b want 0", rdy); end
    n_vec++; if (dout !== 8'h00) begin n_err++; $display("FAIL reset_dout: got %h want 00", dout); end
    n_vec++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin
      n_err++; $display("FAIL reset_pulses: got fe=%b ov=%b want 0 0", frame_err, overrun); end
    n_vec++; if (dut.state !== ST_IDLE) begin n_err++; $display("FAIL reset_state: got %0d want IDLE", dut.state); end
    rst = 1'b0;
    drive_bit(1'b1, 50, 1'b0);
  endtask

  task automatic test_basic();
    send_frame(8'hA5, 1'b1, ^8'hA5, 1'b0);
    n_vec++; if (rdy_rise - stop_start < 240 || rdy_rise - stop_start > 285) begin
      n_err++; $display("FAIL basic_rdy_timing: rdy rose %0d clks into stop bit, want 240..285", rdy_rise - stop_start); end
    n_vec++; if (rdy !== 1'b1) begin n_err++; $display("FAIL basic_rdy: got %b want 1", rdy); end
    n_vec++; if (dout !== 8'hA5) begin n_err++; $display("FAIL basic_dout: got %h want a5", dout); end
    n_vec++; if (fe_hi !== 0) begin n_err++; $display("FAIL basic_fe: got %0d want 0", fe_hi); end
    pop_byte();
    n_vec++; if (rdy !== 1'b0) begin n_err++; $display("FAIL basic_pop_rdy: got %b want 0", rdy); end
  endtask

  task automatic test_glitch();
    frame_cyc = 0; fe_hi = 0; ov_hi = 0; rdy_rise = -1; rdy_prev = rdy;
    drive_bit(1'b0, 81, 1'b0);      // 3 ticks of 27 clocks
    drive_bit(1'b1, 800, 1'b0);
    n_vec++; if (rdy !== 1'b0) begin n_err++; $display("FAIL glitch_rdy: got %b want 0", rdy); end
    n_vec++; if (fe_hi !== 0) begin n_err++; $display("FAIL glitch_fe: got %0d want 0", fe_hi); end
    n_vec++; if (dut.state !== ST_IDLE) begin n_err++; $display("FAIL glitch_state: got %0d want IDLE", dut.state); end
  endtask

  task automatic test_frame_err();
    send_frame(8'h3C, 1'b0, ^8'h3C, 1'b0);
    n_vec++; if (fe_hi !== 1) begin n_err++; $display("FAIL ferr_pulse: got %0d cycles want 1", fe_hi); end
    n_vec++; if (rdy !== 1'b0 || rdy_rise >= 0) begin n_err++; $display("FAIL ferr_rdy: got %b (rise %0d) want 0", rdy, rdy_rise); end
    n_vec++; if (dut.state !== ST_IDLE) begin n_err++; $display("FAIL ferr_state: got %0d want IDLE", dut.state); end
  endtask

  task automatic test_overrun();
    logic [7:0] exp_q [8];
    ov_total = 0;
    for (int i = 0; i < 9; i++) begin
      logic [7:0] d;
      d = 8'(i);
      send_frame(d, 1'b1, ^d, 1'b0);
      ov_total += ov_hi;
      if (i == 7) begin
        n_vec++; if (ov_total !== 0) begin n_err++; $display("FAIL ovr_early: got %0d pulses want 0", ov_total); end
      end
    end
    n_vec++; if (ov_hi !== 1) begin n_err++; $display("FAIL ovr_pulse: got %0d cycles want 1", ov_hi); end
    n_vec++; if (dout !== 8'h00 || rdy !== 1'b1) begin n_err++; $display("FAIL ovr_head: got rdy=%b dout=%h want 1 00", rdy, dout); end
    // Full FIFO: pop head (0x00) in the very cycle 0x09 is pushed.
    send_frame(8'h09, 1'b1, ^8'h09, 1'b1);
    n_vec++; if (ov_hi !== 0) begin n_err++; $display("FAIL b2b_overrun: got %0d want 0", ov_hi); end
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h09};
    for (int i = 0; i < 8; i++) begin
      n_vec++; if (rdy !== 1'b1 || dout !== exp_q[i]) begin
        n_err++; $display("FAIL ovr_read%0d: got rdy=%b dout=%h want 1 %h", i, rdy, dout, exp_q[i]); end
      pop_byte();
    end
    n_vec++; if (rdy !== 1'b0) begin n_err++; $display("FAIL ovr_drained: got %b want 0", rdy); end
  endtask

  task automatic test_reset_mid();
    send_frame(8'h99, 1'b1, ^8'h99, 1'b0);
    n_vec++; if (dout !== 8'h99) begin n_err++; $display("FAIL rmid_pre: got %h want 99", dout); end
    drive_bit(1'b0, BIT_CLKS, 1'b0);        // start bit of 0x55
    drive_bit(1'b1, BIT_CLKS, 1'b0);        // bit0
    drive_bit(1'b0, BIT_CLKS / 2, 1'b0);    // half of bit1
    rst = 1'b1; rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    n_vec++; if (rdy !== 1'b0 || dout !== 8'h00) begin n_err++; $display("FAIL rmid_flush: got rdy=%b dout=%h want 0 00", rdy, dout); end
    n_vec++; if (dut.state !== ST_IDLE) begin n_err++; $display("FAIL rmid_state: got %0d want IDLE", dut.state); end
    drive_bit(1'b1, 100, 1'b0);
    send_frame(8'h12, 1'b1, ^8'h12, 1'b0);
    n_vec++; if (rdy !== 1'b1 || dout !== 8'h12) begin n_err++; $display("FAIL rmid_next: got rdy=%b dout=%h want 1 12", rdy, dout); end
    pop_byte();
    n_vec++; if (rdy !== 1'b0) begin n_err++; $display("FAIL rmid_pop: got %b want 0", rdy); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    send_frame(8'h07, 1'b1, 1'b0, 1'b0);
    n_vec++; if (fe_hi !== 1) begin n_err++; $display("FAIL par_bad_fe: got %0d want 1", fe_hi); end
    n_vec++; if (rdy !== 1'b0) begin n_err++; $display("FAIL par_bad_rdy: got %b want 0", rdy); end
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    n_vec++; if (rdy !== 1'b1 || dout !== 8'h07 || fe_hi !== 0) begin
      n_err++; $display("FAIL par_good: got rdy=%b dout=%h fe=%0d want 1 07 0", rdy, dout, fe_hi); end
    pop_byte();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_reset_mid();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
